instruction_fetch: RTL and testbench

Fetch front end between the program counter and instruction memory. It issues word reads at the current PC over a valid/ready request channel and captures responses into a small in-order queue. It presents instructions with their PC to the decoder over a valid/ready channel. It steps the PC with a count-enable pulse per accepted request and discards in-flight work on a redirect (flush).

---
 rtl/instruction_fetch_pkg.sv | 27 ++
 rtl/fetch_queue.sv | 70 +++++++
 rtl/instruction_fetch.sv | 189 ++++++++++++++++++
 tb/tb_instruction_fetch.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared types for the instruction fetch front end: fetch FSM states,
// instruction queue entry layout and the NOP word used for fault entries.
package instruction_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic        fault;
    } fetch_entry_t;

    localparam logic [31:0]  NOP_INSTR   = 32'h0000_0013;
    localparam fetch_entry_t EMPTY_ENTRY = '{data: 32'h0000_0000, pc: 32'h0000_0000, fault: 1'b0};

    // Word fetches require the two low address bits to be zero.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order instruction queue: synchronous FIFO of DEPTH entries with clear,
// occupancy count and a head view driven straight from storage flops.
module fetch_queue
    import instruction_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    input  logic                       clear,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output fetch_entry_t               head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    fetch_entry_t   mem_r [DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [AW:0]    count_r;
    logic           full_s;
    logic           empty_s;
    logic           push_ok_s;
    logic           pop_ok_s;

    assign full_s    = (count_r == DEPTH_C);
    assign empty_s   = (count_r == {(AW+1){1'b0}});
    // A push into a full queue is only allowed when the head leaves in the same cycle.
    assign push_ok_s = push && (!full_s || pop);
    assign pop_ok_s  = pop && !empty_s;

    // Storage, pointers and occupancy; clear wins over push and pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= EMPTY_ENTRY;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else if (clear) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_entry;
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1'b1);
                2'b01:   count_r <= count_r - (AW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign count = count_r;
    assign empty = empty_s;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: issues one outstanding word read at the PC, queues responses
// in order for the decoder, and discards in-flight work on flush.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned PCs push a NOP fault entry and halt.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pcIn,
    output logic        pcCountEnable,
    input  logic        flush,
    output logic        memReqValid,
    input  logic        memReqReady,
    output logic [31:0] memAddr,
    input  logic        memRespValid,
    input  logic [31:0] memRespData,
    output logic        instrValid,
    input  logic        instrReady,
    output logic [31:0] instrData,
    output logic [31:0] instrPc,
    output logic        instrFault
);

    localparam int AW = $clog2(QUEUE_DEPTH);

    fetch_state_t  state_r;
    fetch_state_t  state_nxt_s;
    logic [31:0]   req_pc_r;
    logic [AW:0]   count_s;
    logic [AW+1:0] count_after_push_s;
    logic          empty_s;
    logic          credit_s;
    logic          credit_after_push_s;
    logic          misaligned_s;
    logic          accept_s;
    logic          push_s;
    logic          pop_s;
    fetch_entry_t  push_entry_s;
    fetch_entry_t  head_s;

    assign pop_s = !empty_s && instrReady;

    // Credit compares occupancy only: a request is issued solely when nothing is outstanding.
    assign credit_s            = (count_s < (AW+1)'(QUEUE_DEPTH));
    assign count_after_push_s  = {1'b0, count_s} + (AW+2)'(1'b1) - {{(AW+1){1'b0}}, pop_s};
    assign credit_after_push_s = (count_after_push_s < (AW+2)'(QUEUE_DEPTH));

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned_s = is_misaligned(pcIn[1:0]);
`else
    assign misaligned_s = 1'b0;
`endif

    // Next-state decode, request channel and queue push; flush overrides all.
    always_comb begin
        state_nxt_s   = state_r;
        memReqValid   = 1'b0;
        memAddr       = 32'h0000_0000;
        pcCountEnable = 1'b0;
        accept_s      = 1'b0;
        push_s        = 1'b0;
        push_entry_s  = '{data: memRespData, pc: req_pc_r, fault: 1'b0};
        case (state_r)
            ST_IDLE: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (credit_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!misaligned_s) begin
                    memReqValid = 1'b1;
                    memAddr     = pcIn;
                    if (memReqReady) begin
                        accept_s = 1'b1;
                        if (flush) begin
                            state_nxt_s = ST_DRAIN;
                        end else begin
                            pcCountEnable = 1'b1;
                            state_nxt_s   = ST_WAIT;
                        end
                    end else if (flush) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_REQ;
                    end
                end else begin
`ifdef FETCH_ALIGN_CHECK_EN
                    if (flush) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        push_s       = 1'b1;
                        push_entry_s = '{data: NOP_INSTR, pc: pcIn, fault: 1'b1};
                        state_nxt_s  = ST_HALT;
                    end
`else
                    state_nxt_s = ST_IDLE;
`endif
                end
            end
            ST_WAIT: begin
                if (memRespValid) begin
                    if (flush) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        push_s      = 1'b1;
                        state_nxt_s = credit_after_push_s ? ST_REQ : ST_IDLE;
                    end
                end else if (flush) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                // The stale response is consumed even if another flush coincides with it.
                if (memRespValid) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            ST_HALT: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
`endif
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // PC of the outstanding request, attached to its response on push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_pc_r <= 32'h0000_0000;
        end else if (accept_s) begin
            req_pc_r <= pcIn;
        end else begin
            req_pc_r <= req_pc_r;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .clear      (flush),
        .count      (count_s),
        .empty      (empty_s),
        .head       (head_s)
    );

    assign instrValid = !empty_s;
    assign instrData  = head_s.data;
    assign instrPc    = head_s.pc;

`ifdef FETCH_ALIGN_CHECK_EN
    assign instrFault = head_s.fault;
`else
    logic unused_fault_s;
    assign unused_fault_s = head_s.fault;
    assign instrFault     = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: startup vector table, directed
// corner sequences and a randomized run against a transaction-level model.
module tb_instruction_fetch;

    localparam int QD = 2;

    logic        clk;
    logic        reset;
    logic [31:0] pcIn;
    logic        pcCountEnable;
    logic        flush;
    logic        memReqValid;
    logic        memReqReady;
    logic [31:0] memAddr;
    logic        memRespValid;
    logic [31:0] memRespData;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instrData;
    logic [31:0] instrPc;
    logic        instrFault;

    instruction_fetch #(.QUEUE_DEPTH(QD)) dut (
        .clk           (clk),
        .reset         (reset),
        .pcIn          (pcIn),
        .pcCountEnable (pcCountEnable),
        .flush         (flush),
        .memReqValid   (memReqValid),
        .memReqReady   (memReqReady),
        .memAddr       (memAddr),
        .memRespValid  (memRespValid),
        .memRespData   (memRespData),
        .instrValid    (instrValid),
        .instrReady    (instrReady),
        .instrData     (instrData),
        .instrPc       (instrPc),
        .instrFault    (instrFault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: PC register, memory with one pending read, expected queue.
    logic [31:0] pc_model;
    logic [31:0] mem_addr_q;
    bit          mem_pending;
    int          mem_wait;
    bit          live;
    logic [31:0] exp_q[$];
    bit          model_en;

    // Values sampled mid-cycle by cyc().
    bit          smp_rv, smp_pce, smp_iv, smp_ifault;
    logic [31:0] smp_addr, smp_ipc, smp_idata;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        reset = 1'b1; memReqReady = 1'b0; instrReady = 1'b0; flush = 1'b0;
        memRespValid = 1'b0; memRespData = 32'h0; pcIn = start_pc;
        pc_model = start_pc; exp_q.delete(); mem_pending = 1'b0; mem_wait = 0; live = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    // One clock cycle: drive inputs, sample outputs, check against model, advance model.
    task automatic cyc(input bit rr, input bit ir, input bit fl, input logic [31:0] npc, input int lat);
        bit resp;
        @(negedge clk);
        resp = mem_pending && (mem_wait == 0);
        pcIn = pc_model; memReqReady = rr; instrReady = ir; flush = fl;
        memRespValid = resp;
        memRespData  = resp ? memfn(mem_addr_q) : $urandom();
        #1;
        smp_rv = memReqValid; smp_pce = pcCountEnable; smp_iv = instrValid;
        smp_addr = memAddr; smp_ipc = instrPc; smp_idata = instrData; smp_ifault = instrFault;
        if (model_en) begin
            chkb("instr_valid", instrValid, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                chk("head_pc", instrPc, exp_q[0]);
                chk("head_data", instrData, memfn(exp_q[0]));
                chkb("head_fault", instrFault, 1'b0);
            end
            if (memReqValid) begin
                chk("req_addr", memAddr, pcIn);
                chkb("one_outstanding", mem_pending, 1'b0);
                chkb("credit", exp_q.size() < QD, 1'b1);
            end else begin
                chk("idle_addr", memAddr, 32'h0);
            end
            chkb("pc_step", pcCountEnable, memReqValid && rr && !fl);
        end
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (smp_iv && ir && exp_q.size() > 0) void'(exp_q.pop_front());
            if (resp && live) exp_q.push_back(mem_addr_q);
        end
        if (resp) begin
            mem_pending = 1'b0; live = 1'b0;
        end
        if (smp_rv && rr) begin
            mem_pending = 1'b1; mem_addr_q = smp_addr; mem_wait = lat - 1; live = !fl;
        end else if (mem_pending && mem_wait > 0) begin
            mem_wait--;
        end
        if (fl) live = 1'b0;
        if (fl) pc_model = npc;
        else if (smp_pce) pc_model = pc_model + 32'd4;
    endtask

    typedef struct {
        bit          rr;
        bit          ir;
        bit          rv;
        bit          pce;
        bit          iv;
        logic [31:0] addr;
        logic [31:0] ipc;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int          n_acc;
        bit          found;
        logic [31:0] first_addr, first_ipc, rnd;

        // Zero-wait startup from PC 0 with the decoder always ready.
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h4,  32'h0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h8,  32'h4};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hC,  32'h8};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0};
        tbl[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 32'hC};

        model_en = 1'b1;
        do_reset(32'h0);
        chkb("rst_instr_valid", instrValid, 1'b0);
        chk("rst_instr_data", instrData, 32'h0);
        chk("rst_instr_pc", instrPc, 32'h0);
        chkb("rst_instr_fault", instrFault, 1'b0);
        chkb("rst_req_valid", memReqValid, 1'b0);
        chkb("rst_pc_step", pcCountEnable, 1'b0);
        chk("rst_mem_addr", memAddr, 32'h0);

        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].rr, tbl[i].ir, 1'b0, 32'h0, 1);
            chkb($sformatf("tbl%0d_req_valid", i), smp_rv, tbl[i].rv);
            chkb($sformatf("tbl%0d_pc_step", i), smp_pce, tbl[i].pce);
            chkb($sformatf("tbl%0d_instr_valid", i), smp_iv, tbl[i].iv);
            chk($sformatf("tbl%0d_mem_addr", i), smp_addr, tbl[i].addr);
            if (tbl[i].iv) chk($sformatf("tbl%0d_instr_pc", i), smp_ipc, tbl[i].ipc);
        end

        // Decoder stalled: only QD requests fit, then one more per pop.
        do_reset(32'h0);
        n_acc = 0;
        for (int i = 0; i < 14; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'h0, 1);
            n_acc += int'(smp_rv);
        end
        chk("stall_requests", n_acc, 32'd2);
        n_acc = 0;
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1);
        n_acc += int'(smp_rv);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'h0, 1);
            n_acc += int'(smp_rv);
        end
        chk("one_more_request", n_acc, 32'd1);
        chkb("stall_req_low", smp_rv, 1'b0);

        // Memory not ready: request held steady with no PC step.
        do_reset(32'h40);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0, 1);
            chkb("hold_req_valid", smp_rv, 1'b1);
            chk("hold_mem_addr", smp_addr, 32'h40);
            chkb("hold_pc_step", smp_pce, 1'b0);
        end
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1);
        chkb("release_pc_step", smp_pce, 1'b1);
        repeat (6) cyc(1'b1, 1'b1, 1'b0, 32'h0, 1);

        // Flush during WAIT with a slow response: it is dropped, fetch restarts at 0x100.
        do_reset(32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1);
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 4);
        cyc(1'b1, 1'b1, 1'b1, 32'h100, 1);
        found = 1'b0; first_addr = 32'hFFFF_FFFF; first_ipc = 32'hFFFF_FFFF;
        for (int i = 0; i < 14; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 32'h0, 1);
            if (smp_rv && first_addr == 32'hFFFF_FFFF) first_addr = smp_addr;
            if (smp_iv && !found) begin
                found = 1'b1; first_ipc = smp_ipc;
            end
        end
        chk("flush_wait_first_addr", first_addr, 32'h100);
        chk("flush_wait_first_pc", first_ipc, 32'h100);

        // Flush with a response in the same cycle and one entry queued.
        do_reset(32'h0);
        repeat (4) cyc(1'b1, 1'b0, 1'b0, 32'h0, 1);
        cyc(1'b1, 1'b0, 1'b1, 32'h200, 1);
        chkb("flush_resp_held", smp_iv, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1);
        chkb("flush_resp_empty", smp_iv, 1'b0);
        found = 1'b0; first_ipc = 32'hFFFF_FFFF;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 32'h0, 1);
            if (smp_iv && !found) begin
                found = 1'b1; first_ipc = smp_ipc;
            end
        end
        chk("flush_resp_next_pc", first_ipc, 32'h200);

`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned PC: fault entry and halt until flush.
        model_en = 1'b0;
        do_reset(32'h102);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1);
        chkb("align_no_req", smp_rv, 1'b0);
        chkb("align_no_step", smp_pce, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'h0, 1);
            chkb("halt_no_req", smp_rv, 1'b0);
            chkb("halt_valid", smp_iv, 1'b1);
            chkb("halt_fault", smp_ifault, 1'b1);
            chk("halt_data", smp_idata, 32'h0000_0013);
            chk("halt_pc", smp_ipc, 32'h102);
        end
        cyc(1'b1, 1'b0, 1'b1, 32'h200, 1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1);
        chkb("halt_exit_req", smp_rv, 1'b1);
        chk("halt_exit_addr", smp_addr, 32'h200);
        model_en = 1'b1;
`endif

        // Randomized traffic against the model.
        rnd = $urandom();
        do_reset(rnd & 32'h00FF_FFFC);
        for (int i = 0; i < 3000; i++) begin
            rnd = $urandom();
            cyc($urandom_range(3, 0) != 0, $urandom_range(9, 0) < 6,
                $urandom_range(39, 0) == 0, rnd & 32'hFFFF_FFFC, int'($urandom_range(3, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
